// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register map, CTRL/STATUS
// bit positions and the chip-select nibble the address decoder matches.
package timer_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    REG_COUNT  = 2'd0,
    REG_RELOAD = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STATUS = 2'd3
  } reg_addr_e;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_AUTO_BIT  = 1;
  localparam int CTRL_IE_BIT    = 2;
  localparam int CTRL_PSC_LSB   = 4;
  localparam int STATUS_OVF_BIT = 0;

  localparam logic [3:0] CHIP_SELECT_NIBBLE = 4'b1010;

  // Reference decode for the external chip select driving 'enable'.
  function automatic logic chip_selected(input logic [15:0] cpu_addr);
    return cpu_addr[15:12] == CHIP_SELECT_NIBBLE;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: emits a one-cycle tick every 2^psc clocks and is
// held at zero while clear is high.
module timer_prescaler #(
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  // Wide enough that the largest select (2^PSC_W - 1) still divides cleanly.
  localparam int CNT_W = (1 << PSC_W) - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d, mask;

  assign mask  = (CNT_W'(1) << psc) - CNT_W'(1);
  assign cnt_d = clear ? '0 : cnt_q + CNT_W'(1);
  assign tick  = !clear && ((cnt_q & mask) == mask);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer.sv
// Memory-mapped down-counting timer with reload, one-shot/auto-reload modes
// and a sticky overflow interrupt. Define TIMER_PRESCALER_EN for a clock prescaler.
module timer
  import timer_pkg::*;
#(
  parameter int PSC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address_bus,
  inout  wire  [DATA_W-1:0] data_bus,
  input  logic              enable,
  input  logic              read,
  input  logic              write,
  output logic              irq
);

  logic [DATA_W-1:0] count_q, count_d, reload_q, reload_d;
  logic              en_q, en_d, auto_q, auto_d, ie_q, ie_d, ovf_q, ovf_d;
  logic [PSC_W-1:0]  psc_rd;
  logic              tick, tick_eff;
  logic              wr_reload, wr_ctrl, wr_status;
  logic [DATA_W-1:0] ctrl_rd, rdata;

  assign wr_reload = enable && write && (address_bus == REG_RELOAD);
  assign wr_ctrl   = enable && write && (address_bus == REG_CTRL);
  assign wr_status = enable && write && (address_bus == REG_STATUS);

  // A CTRL write clearing EN freezes the count on that very edge.
  assign tick_eff = tick && !(wr_ctrl && !data_bus[CTRL_EN_BIT]);

`ifdef TIMER_PRESCALER_EN
  logic [PSC_W-1:0] psc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       psc_q <= '0;
    else if (wr_ctrl) psc_q <= data_bus[CTRL_PSC_LSB +: PSC_W];
  end

  timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (!en_q),
    .psc   (psc_q),
    .tick  (tick)
  );

  assign psc_rd = psc_q;
`else
  assign tick   = en_q;
  assign psc_rd = '0;
`endif

  // NOTE: every next-state signal gets its hold value first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    en_d     = en_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    ovf_d    = ovf_q;

    if (wr_status && data_bus[STATUS_OVF_BIT]) ovf_d = 1'b0;

    // Evaluated after the clear so a coincident overflow keeps OVF set.
    if (tick_eff) begin
      if (count_q == '0) begin
        ovf_d = 1'b1;
        if (auto_q) count_d = reload_q;
        else        en_d    = 1'b0;
      end else begin
        count_d = count_q - DATA_W'(1);
      end
    end

    if (wr_reload) begin
      reload_d = data_bus;
      if (!en_q) count_d = data_bus;
    end

    if (wr_ctrl) begin
      en_d   = data_bus[CTRL_EN_BIT];
      auto_d = data_bus[CTRL_AUTO_BIT];
      ie_d   = data_bus[CTRL_IE_BIT];
      if (!en_q && data_bus[CTRL_EN_BIT]) count_d = reload_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      reload_q <= '0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    ctrl_rd                             = '0;
    ctrl_rd[CTRL_EN_BIT]                = en_q;
    ctrl_rd[CTRL_AUTO_BIT]              = auto_q;
    ctrl_rd[CTRL_IE_BIT]                = ie_q;
    ctrl_rd[CTRL_PSC_LSB +: PSC_W]      = psc_rd;

    rdata = '0;
    case (reg_addr_e'(address_bus))
      REG_COUNT:  rdata = count_q;
      REG_RELOAD: rdata = reload_q;
      REG_CTRL:   rdata = ctrl_rd;
      REG_STATUS: rdata[STATUS_OVF_BIT] = ovf_q;
    endcase
  end

  assign data_bus = (enable && read) ? rdata : {DATA_W{1'bz}};
  assign irq      = ovf_q && ie_q;

endmodule
